// File: rtl/tmr_err_monitor.sv
// rtl/tmr_err_monitor.sv - TMR mismatch monitor: edge count, timestamp, threshold irq, APB regs
module tmr_err_monitor #(
  parameter int CNT_WIDTH      = 16,
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tmr_err_i,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      event_o,
  output logic                      irq_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] THRESH_RST = CNT_WIDTH'(1);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_COUNT  = 3'd2;
  localparam logic [2:0] A_THRESH = 3'd3;
  localparam logic [2:0] A_TSTAMP = 3'd4;

  logic                 en;
  logic                 irq_en;
  logic                 tmr_err_q;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] thresh;
  logic                 st_err;
  logic                 st_thr;
  logic                 st_sat;
  logic [31:0]          tstamp;
  logic [31:0]          cyc;

  logic [2:0]           sel;
  logic                 addr_ok;
  logic                 wr;
  logic                 wr_ctrl;
  logic                 wr_status;
  logic                 wr_thresh;
  logic                 clr;
  logic [2:0]           w1c;
  logic                 err_edge;
  logic                 at_max;
  logic [CNT_WIDTH-1:0] count_inc;
  logic                 thr_hit;
  logic                 unused_apb;

  assign sel       = PADDR[4:2];
  assign addr_ok   = (sel <= A_TSTAMP);
  assign wr        = PSEL & PENABLE & PWRITE & addr_ok;
  assign wr_ctrl   = wr & (sel == A_CTRL);
  assign wr_status = wr & (sel == A_STATUS);
  assign wr_thresh = wr & (sel == A_THRESH);
  assign clr       = wr_ctrl & PWDATA[2];
  assign w1c       = wr_status ? PWDATA[2:0] : 3'b000;

  assign err_edge  = tmr_err_i & ~tmr_err_q & en;
  assign at_max    = (count == CNT_MAX);
  assign count_inc = count + CNT_WIDTH'(1);
  // Threshold only fires on a real increment, so a saturated counter cannot re-arm THR
  assign thr_hit   = err_edge & ~at_max & (count_inc == thresh) & (thresh != '0);

  assign PREADY     = 1'b1;
  assign PSLVERR    = PSEL & PENABLE & ~addr_ok;
  assign unused_apb = ^{PADDR, PWDATA};

  always_comb begin
    PRDATA = 32'd0;
    if (PSEL) begin
      case (sel)
        A_CTRL:   PRDATA = {30'd0, irq_en, en};
        A_STATUS: PRDATA = {29'd0, st_sat, st_thr, st_err};
        A_COUNT:  PRDATA = 32'(count);
        A_THRESH: PRDATA = 32'(thresh);
        A_TSTAMP: PRDATA = tstamp;
        default:  PRDATA = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en        <= 1'b0;
      irq_en    <= 1'b0;
      tmr_err_q <= 1'b0;
      count     <= '0;
      thresh    <= THRESH_RST;
      st_err    <= 1'b0;
      st_thr    <= 1'b0;
      st_sat    <= 1'b0;
      tstamp    <= 32'd0;
      cyc       <= 32'd0;
      event_o   <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      cyc       <= cyc + 32'd1;
      tmr_err_q <= tmr_err_i;
      event_o   <= err_edge;
      irq_o     <= irq_en & st_thr;

      if (wr_ctrl) begin
        en     <= PWDATA[0];
        irq_en <= PWDATA[1];
      end
      if (wr_thresh) begin
        thresh <= PWDATA[CNT_WIDTH-1:0];
      end

      // CLR beats a coincident edge: the edge still pulses event_o but leaves no trace
      if (clr) begin
        count  <= '0;
        st_err <= 1'b0;
        st_thr <= 1'b0;
        st_sat <= 1'b0;
      end else begin
        if (err_edge) begin
          tstamp <= cyc;
          if (!at_max) begin
            count <= count_inc;
          end
        end
        st_err <= (st_err & ~w1c[0]) | err_edge;
        st_thr <= (st_thr & ~w1c[1]) | thr_hit;
        st_sat <= (st_sat & ~w1c[2]) | (err_edge & at_max);
      end
    end
  end

endmodule
